// File: rtl/env_vca_pkg.sv
// Shared synth constants and the VCA multiplier state encoding.
package synth_pkg;
  localparam int PCM_QUANT    = 16;
  localparam int ENV_DIV_LOG2 = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } vca_state_t;
endpackage

// File: rtl/env_vca_if.sv
// Envelope timebase and sample stream bundle between source, VCA and downstream.
interface env_vca_if
  import synth_pkg::*;
#(
  parameter int W = PCM_QUANT
);
  logic         note_on;
  logic         env_tick;
  logic         env_clr;
  logic [W-1:0] env_y;
  logic [W-1:0] smp_in;
  logic         smp_valid;
  logic         smp_ready;
  logic [W-1:0] out;
  logic         out_valid;

  modport master (
    output note_on, env_y, smp_in, smp_valid,
    input  env_tick, env_clr, smp_ready, out, out_valid
  );

  modport slave (
    input  note_on, env_y, smp_in, smp_valid,
    output env_tick, env_clr, smp_ready, out, out_valid
  );
endinterface

// File: rtl/vca_serial_mul.sv
// Serial shift-add multiplier: signed sample x unsigned envelope, one env bit per cycle,
// returns the upper half of the 2W-bit product (arithmetic >> W, floor).
module vca_serial_mul
  import synth_pkg::*;
#(
  parameter int W = PCM_QUANT
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_smp,
  input  logic [W-1:0] i_env,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_prod
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [1:0]    S_IDLE = ST_IDLE;
  localparam logic [1:0]    S_MUL  = ST_MUL;
  localparam logic [1:0]    S_DONE = ST_DONE;
  localparam logic [IW-1:0] LAST   = IW'(W - 1);

  logic [1:0]     r_state;
  logic [IW-1:0]  r_idx;
  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_mplier;
  logic [W-1:0]   r_prod;
  logic [2*W-1:0] w_acc_nxt;

  // Multiplicand walks left while the env snapshot walks right, so bit 0 is always the current one.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mcand  <= {{W{i_smp[W-1]}}, i_smp};
          r_mplier <= i_env;
          r_acc    <= '0;
          r_idx    <= '0;
          r_state  <= S_MUL;
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            // Loaded here so the result is already visible in the DONE cycle.
            r_prod  <= w_acc_nxt[2*W-1:W];
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);
  assign o_prod = r_prod;
endmodule

// File: rtl/env_vca.sv
// VCA stage: envelope prescaler/restart flag plus handshake glue around the serial multiplier.
module env_vca
  import synth_pkg::*;
#(
  parameter int W        = PCM_QUANT,
  parameter int DIV_LOG2 = ENV_DIV_LOG2
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  env_vca_if.slave  bus
);
  logic [DIV_LOG2-1:0] r_div;
  logic                r_pend;
  logic                r_ready;
  logic                w_tick;
  logic                w_start;
  logic                w_busy;
  logic                w_done;
  logic [W-1:0]        w_prod;

  assign w_tick  = &r_div;
  assign w_start = bus.smp_valid & r_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div   <= '0;
      r_pend  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_div   <= r_div + 1'b1;
      // A note_on landing on the consuming tick keeps the restart pending.
      r_pend  <= bus.note_on | (r_pend & ~w_tick);
      // Ready exactly when the multiplier will be idle next cycle.
      r_ready <= (~w_busy & ~w_start) | w_done;
    end
  end

  vca_serial_mul #(.W(W)) u_mul (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_start),
    .i_smp   (bus.smp_in),
    .i_env   (bus.env_y),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_prod  (w_prod)
  );

  assign bus.env_tick  = w_tick;
  assign bus.env_clr   = r_pend;
  assign bus.smp_ready = r_ready;
  assign bus.out       = w_prod;
  assign bus.out_valid = w_done;
endmodule

// File: tb/tb_env_vca.sv
// Directed bench for env_vca: timebase, restart flag, multiply results, handshake, reset abort.
module tb_env_vca;
  localparam int W  = 16;
  localparam int DL = 8;  // short prescaler keeps tick-period checks brief

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  env_vca_if #(.W(W)) bus ();

  env_vca #(.W(W), .DIV_LOG2(DL)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.env_tick && n < 2000);
  endtask

  // Counts cycles from now through the next tick inclusive, requiring env_clr high throughout.
  task automatic clr_span(output int n, output bit ok);
    n  = 0;
    ok = 1'b1;
    forever begin
      if (!bus.env_clr) ok = 1'b0;
      n++;
      if (bus.env_tick || n >= 2000) break;
      @(negedge clk);
    end
  endtask

  task automatic mul_run(input string tag, input logic [15:0] s, input logic [15:0] e,
                         input logic [15:0] x, input bit wiggle);
    int n;
    n = 0;
    while (!bus.smp_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.smp_in    = s;
    bus.env_y     = e;
    bus.smp_valid = 1'b1;
    @(negedge clk);
    bus.smp_valid = 1'b0;
    bus.smp_in    = '0;
    n = 1;
    while (!bus.out_valid && n < 100) begin
      if (wiggle) bus.env_y = 16'($urandom);
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 17);
    chk({tag, "_out"}, bus.out, x);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.out_valid, 0);
    chk({tag, "_hold"}, bus.out, x);
    chk({tag, "_rdy"}, bus.smp_ready, 1);
  endtask

  initial begin
    int n, a0, a1, a2, vcnt;
    bit ok;
    logic [15:0] got;

    bus.note_on   = 1'b0;
    bus.env_y     = '0;
    bus.smp_in    = '0;
    bus.smp_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tick",  bus.env_tick,  0);
    chk("rst_clr",   bus.env_clr,   0);
    chk("rst_out",   bus.out,       0);
    chk("rst_vld",   bus.out_valid, 0);
    chk("rst_ready", bus.smp_ready, 0);

    // Timebase
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rel", bus.smp_ready, 1);
    chk("no_early_tick",   bus.env_tick,  0);
    wait_tick(n);
    chk("first_tick", n + 1, 255);
    @(negedge clk);
    chk("tick_one_cycle", bus.env_tick, 0);
    wait_tick(n);
    chk("tick_period", n + 1, 256);

    // note_on mid-period: counter at 99 here, clr spans counts 100..255
    repeat (100) @(negedge clk);
    bus.note_on = 1'b1;
    @(negedge clk);
    bus.note_on = 1'b0;
    clr_span(n, ok);
    chk("clr_high",  ok, 1);
    chk("clr_span",  n, 156);
    @(negedge clk);
    chk("clr_low_after", bus.env_clr, 0);

    // note_on coincident with the consuming tick
    bus.note_on = 1'b1;
    @(negedge clk);
    bus.note_on = 1'b0;
    chk("clr_set2", bus.env_clr, 1);
    wait_tick(n);
    bus.note_on = 1'b1;
    @(negedge clk);
    bus.note_on = 1'b0;
    chk("clr_set_wins", bus.env_clr, 1);
    clr_span(n, ok);
    chk("clr_high2", ok, 1);
    chk("clr_span2", n, 256);
    @(negedge clk);
    chk("clr_low_after2", bus.env_clr, 0);

    // Multiply vectors; results are floor(smp*env / 2^16)
    mul_run("m_half",   16'h4000, 16'h8000, 16'h2000, 1'b0);
    // -32768*65535/65536 = -32767.5 -> floor -32768
    mul_run("m_negmax", 16'h8000, 16'hFFFF, 16'h8000, 1'b0);
    mul_run("m_neg1",   16'hFFFF, 16'h0001, 16'hFFFF, 1'b0);
    mul_run("m_posmax", 16'h7FFF, 16'hFFFF, 16'h7FFE, 1'b1);
    mul_run("m_neg2",   16'hFFFE, 16'h8000, 16'hFFFF, 1'b0);
    mul_run("m_zero",   16'h1234, 16'h0000, 16'h0000, 1'b0);

    // Back-to-back with smp_valid held
    bus.smp_in    = 16'h0100;
    bus.env_y     = 16'h0100;
    bus.smp_valid = 1'b1;
    a0 = -1; a1 = -1; a2 = -1;
    got = 16'hDEAD;
    for (int c = 0; c < 60; c++) begin
      if (bus.smp_ready) begin
        if (a0 < 0) a0 = c;
        else if (a1 < 0) a1 = c;
        else if (a2 < 0) a2 = c;
      end
      if (bus.out_valid) got = bus.out;
      @(negedge clk);
    end
    bus.smp_valid = 1'b0;
    chk("b2b_gap1", a1 - a0, 18);
    chk("b2b_gap2", a2 - a1, 18);
    chk("b2b_out",  got, 16'h0001);

    // Reset at MUL iteration 5 aborts the sample
    n = 0;
    while (!bus.smp_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.smp_in    = 16'h4000;
    bus.env_y     = 16'h8000;
    bus.smp_valid = 1'b1;
    @(negedge clk);
    bus.smp_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    vcnt  = 0;
    repeat (2) begin
      @(negedge clk);
      vcnt += int'(bus.out_valid);
    end
    chk("abort_out",   bus.out,       0);
    chk("abort_ready", bus.smp_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_rel", bus.smp_ready, 1);
    repeat (20) begin
      vcnt += int'(bus.out_valid);
      @(negedge clk);
    end
    chk("abort_no_valid", vcnt, 0);
    mul_run("m_fresh", 16'h1234, 16'hFFFF, 16'h1233, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
